// File: rtl/phys_reg_file_mp_pkg.sv
// Shared types and default sizing for the multi-port physical register file.
package phys_reg_file_mp_pkg;

  localparam int unsigned PRF_DATA_WIDTH = 32;
  localparam int unsigned PRF_PHY_REGS   = 64;
  localparam int unsigned PRF_PHY_WIDTH  = $clog2(PRF_PHY_REGS);
  localparam int unsigned PRF_NUM_RD     = 6;
  localparam int unsigned PRF_NUM_WB     = 3;
  localparam int unsigned PRF_NUM_ALLOC  = 2;

  typedef logic [PRF_PHY_WIDTH-1:0]  phy_tag_t;
  typedef logic [PRF_DATA_WIDTH-1:0] prf_data_t;

  localparam phy_tag_t PRF_ZERO_TAG = '0;

endpackage

// File: rtl/phys_reg_file_mp_ready_table.sv
// Per-register ready scoreboard: resolves allocate / writeback / flush per cycle.
module prf_ready_table
  import phys_reg_file_mp_pkg::*;
#(
  parameter int unsigned PHY_REGS  = PRF_PHY_REGS,
  parameter int unsigned PHY_WIDTH = $clog2(PHY_REGS),
  parameter int unsigned NUM_WB    = PRF_NUM_WB,
  parameter int unsigned NUM_ALLOC = PRF_NUM_ALLOC
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [NUM_ALLOC-1:0]           alloc_valid,
  input  logic [NUM_ALLOC*PHY_WIDTH-1:0] alloc_tag,
  input  logic [NUM_WB-1:0]              wb_valid,
  input  logic [NUM_WB*PHY_WIDTH-1:0]    wb_tag,
  output logic [PHY_REGS-1:0]            ready_vec
);

  localparam logic [PHY_WIDTH-1:0] ZERO_TAG = PHY_WIDTH'(PRF_ZERO_TAG);

  logic [PHY_WIDTH-1:0] alloc_tags [NUM_ALLOC];
  logic [PHY_WIDTH-1:0] wb_tags    [NUM_WB];
  logic [PHY_REGS-1:0]  ready_q;
  logic [PHY_REGS-1:0]  ready_next;

  always_comb begin
    for (int unsigned a = 0; a < NUM_ALLOC; a++)
      alloc_tags[a] = alloc_tag[a*PHY_WIDTH +: PHY_WIDTH];
    for (int unsigned w = 0; w < NUM_WB; w++)
      wb_tags[w] = wb_tag[w*PHY_WIDTH +: PHY_WIDTH];
  end

  // Order of application sets priority: writeback sets, flush overrides to
  // all-ready, allocate clears last (dropped entirely under flush).
  always_comb begin
    ready_next = ready_q;
    for (int unsigned w = 0; w < NUM_WB; w++)
      if (wb_valid[w])
        ready_next[wb_tags[w]] = 1'b1;
    if (flush) begin
      ready_next = '1;
    end else begin
      for (int unsigned a = 0; a < NUM_ALLOC; a++)
        if (alloc_valid[a] && (alloc_tags[a] != ZERO_TAG))
          ready_next[alloc_tags[a]] = 1'b0;
    end
    ready_next[ZERO_TAG] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ready_q <= '1;
    else
      ready_q <= ready_next;
  end

  assign ready_vec = ready_q;

endmodule

// File: rtl/phys_reg_file_mp.sv
// Multi-port physical register file with ready scoreboard and writeback conflict flag.
// Optional same-cycle writeback-to-read forwarding when PRF_BYPASS_EN is defined.
module phys_reg_file_mp
  import phys_reg_file_mp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PRF_DATA_WIDTH,
  parameter int unsigned PHY_REGS   = PRF_PHY_REGS,
  parameter int unsigned PHY_WIDTH  = $clog2(PHY_REGS),
  parameter int unsigned NUM_RD     = PRF_NUM_RD,
  parameter int unsigned NUM_WB     = PRF_NUM_WB,
  parameter int unsigned NUM_ALLOC  = PRF_NUM_ALLOC
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [NUM_ALLOC-1:0]           alloc_valid,
  input  logic [NUM_ALLOC*PHY_WIDTH-1:0] alloc_tag,
  input  logic [NUM_RD*PHY_WIDTH-1:0]    rd_tag,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_RD-1:0]              rd_ready,
  input  logic [NUM_WB-1:0]              wb_valid,
  input  logic [NUM_WB*PHY_WIDTH-1:0]    wb_tag,
  input  logic [NUM_WB*DATA_WIDTH-1:0]   wb_data,
  output logic [PHY_REGS-1:0]            ready_vec,
  output logic                           wb_conflict
);

  localparam logic [PHY_WIDTH-1:0] ZERO_TAG = PHY_WIDTH'(PRF_ZERO_TAG);

  logic [DATA_WIDTH-1:0] mem       [PHY_REGS];
  logic [PHY_WIDTH-1:0]  wb_tags   [NUM_WB];
  logic [DATA_WIDTH-1:0] wb_words  [NUM_WB];
  logic [NUM_WB-1:0]     wb_we;
  logic [PHY_WIDTH-1:0]  rd_tags   [NUM_RD];
  logic [DATA_WIDTH-1:0] rd_words  [NUM_RD];
  logic [NUM_RD-1:0]     rd_rdy;
  logic                  conflict;
  logic                  conflict_q;

  always_comb begin
    for (int unsigned w = 0; w < NUM_WB; w++) begin
      wb_tags[w]  = wb_tag[w*PHY_WIDTH +: PHY_WIDTH];
      wb_words[w] = wb_data[w*DATA_WIDTH +: DATA_WIDTH];
      wb_we[w]    = wb_valid[w] && (wb_tags[w] != ZERO_TAG);
    end
    for (int unsigned r = 0; r < NUM_RD; r++)
      rd_tags[r] = rd_tag[r*PHY_WIDTH +: PHY_WIDTH];
  end

  prf_ready_table #(
    .PHY_REGS  (PHY_REGS),
    .PHY_WIDTH (PHY_WIDTH),
    .NUM_WB    (NUM_WB),
    .NUM_ALLOC (NUM_ALLOC)
  ) u_ready_table (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .alloc_valid (alloc_valid),
    .alloc_tag   (alloc_tag),
    .wb_valid    (wb_valid),
    .wb_tag      (wb_tag),
    .ready_vec   (ready_vec)
  );

  // Ports are applied in ascending order so the highest-index writer lands last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < PHY_REGS; i++)
        mem[i] <= '0;
    end else begin
      for (int unsigned w = 0; w < NUM_WB; w++)
        if (wb_we[w])
          mem[wb_tags[w]] <= wb_words[w];
    end
  end

  always_comb begin
    conflict = 1'b0;
    for (int unsigned i = 0; i < NUM_WB; i++)
      for (int unsigned j = i + 1; j < NUM_WB; j++)
        if (wb_we[i] && wb_we[j] && (wb_tags[i] == wb_tags[j]))
          conflict = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      conflict_q <= 1'b0;
    else
      conflict_q <= conflict;
  end

  assign wb_conflict = conflict_q;

  always_comb begin
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      rd_words[r] = (rd_tags[r] == ZERO_TAG) ? '0 : mem[rd_tags[r]];
      rd_rdy[r]   = ready_vec[rd_tags[r]];
`ifdef PRF_BYPASS_EN
      // wb_we already excludes tag 0, so the zero register is never forwarded.
      for (int unsigned w = 0; w < NUM_WB; w++)
        if (wb_we[w] && (wb_tags[w] == rd_tags[r])) begin
          rd_words[r] = wb_words[w];
          rd_rdy[r]   = 1'b1;
        end
`endif
    end
  end

  always_comb begin
    rd_data  = '0;
    rd_ready = '0;
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      rd_data[r*DATA_WIDTH +: DATA_WIDTH] = rd_words[r];
      rd_ready[r]                         = rd_rdy[r];
    end
  end

endmodule

// File: doc/phys_reg_file_mp.md
Name: phys_reg_file_mp

Overview:
- Parametrised multi-port physical register file plus per-register ready scoreboard for the out-of-order core.
- Sits between rename (allocation marks a register not-ready), the issue/execute units (operand read plus ready query) and writeback (data write marks ready).
- Generalises the single-issue PRF:
  - configurable read, writeback and allocate port counts;
  - hardwired zero register;
  - posedge timing;
  - deterministic write-port priority;
  - conflict detection.

Parameters:
- DATA_WIDTH, 32, width of one register.
- PHY_REGS, 64, number of physical registers; power of two, at least 4.
- PHY_WIDTH, $clog2(PHY_REGS), tag width. Derived; do not override.
- NUM_RD, 6, number of read ports. Each operand is one port.
- NUM_WB, 3, number of writeback ports.
- NUM_ALLOC, 2, number of rename allocate ports.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  pipeline flush.
- alloc_valid  in  NUM_ALLOC  per-port allocate enable.
- alloc_tag  in  NUM_ALLOC*PHY_WIDTH  tag to mark not-ready; port i occupies slice i.
- rd_tag  in  NUM_RD*PHY_WIDTH  read addresses.
- rd_data  out  NUM_RD*DATA_WIDTH  read data.
- rd_ready  out  NUM_RD  ready bit of the addressed register.
- wb_valid  in  NUM_WB  writeback enable.
- wb_tag  in  NUM_WB*PHY_WIDTH  writeback destination tag.
- wb_data  in  NUM_WB*DATA_WIDTH  writeback data.
- ready_vec  out  PHY_REGS  full ready scoreboard, for issue-queue wakeup.
- wb_conflict  out  1  registered pulse: two or more valid writebacks to the same nonzero tag in one cycle.

Behaviour:
- All state updates on posedge clk. Reset is asynchronous.
- Reset:
  - all data = 0;
  - ready_vec = all ones;
  - wb_conflict = 0.
  - rd_data and rd_ready follow combinationally from the reset state.
- Tag 0:
  - reads always return 0 with ready = 1;
  - writes and allocates to tag 0 are ignored.
- Read ports: combinational, no valid gating, no X output.
  - rd_data[i] = data[rd_tag[i]];
  - rd_ready[i] = ready_vec[rd_tag[i]].
- Writeback: for each valid port with nonzero tag, data[tag] <= wb_data and ready[tag] <= 1 on the next edge. Write latency 1 cycle.
- Same-tag writeback conflict: the highest-index port wins for data. wb_conflict is 1 in the following cycle for exactly one cycle.
- Allocate: for each valid port with nonzero tag, ready[tag] <= 0.
- Allocate and writeback to the same tag in one cycle:
  - allocate wins the ready bit (result 0);
  - the data write still occurs.
- Two allocate ports with the same tag: legal, result not-ready.
- flush:
  - ready_vec <= all ones;
  - data is retained;
  - allocates in the same cycle are dropped;
  - writebacks in the same cycle still write data.
- Reset asserted mid-operation overrides everything immediately. Pending writes are lost.
- Read during a same-cycle write returns old data, unless PRF_BYPASS_EN is defined.

Optional Feature:
- Macro: PRF_BYPASS_EN.
- Defined:
  - rd_data[i] forwards the winning same-cycle wb_data (highest-index valid port) when wb_tag matches nonzero rd_tag[i];
  - rd_ready[i] = 1 in that case;
  - adds combinational path wb -> rd.
- Undefined:
  - no forwarding;
  - new value visible the cycle after the write edge.

Decomposition:
- Shared package gets:
  - typedef phy_tag_t of PHY_WIDTH bits;
  - typedef prf_data_t of DATA_WIDTH bits;
  - constant PRF_ZERO_TAG = 0.
  - Existing parameter_pkg supplies the defaults.
- One sub-module, prf_ready_table:
  - holds ready_vec;
  - handles the allocate/writeback/flush priority;
  - outputs ready_vec.
- The data array and the read/bypass logic stay in the top module.

Test Plan:
- Reset:
  - assert rst mid-cycle -> ready_vec = 64'hFFFF_FFFF_FFFF_FFFF immediately;
  - every rd_data = 0;
  - wb_conflict = 0.
- Alloc then writeback:
  - alloc tag 5 at cycle 0 -> rd_ready(5) = 0 at cycle 1;
  - wb tag 5 data 32'hDEAD_BEEF at cycle 2 -> cycle 3 read returns 32'hDEAD_BEEF, ready 1.
- Zero register:
  - wb tag 0 data 32'h1234 -> reads of tag 0 return 0, ready 1;
  - alloc tag 0 -> ready_vec[0] stays 1.
- Conflict:
  - wb ports 0 and 2 both tag 9, data 1 and 2 -> tag 9 reads 2 next cycle;
  - wb_conflict high for exactly one cycle.
- Alloc/wb/flush ordering:
  - alloc and wb tag 7 same cycle -> ready 0, data updated;
  - then flush with alloc tag 8 -> tags 7 and 8 ready, data of 7 retained.
- Bypass:
  - with PRF_BYPASS_EN, wb tag 12 data 32'hA5A5 while reading tag 12 -> same cycle rd_data = 32'hA5A5, ready 1;
  - without the macro -> old value that cycle, 32'hA5A5 next cycle.
